ws2812b_anim_ctrl: RTL and testbench
====================================

Name: ws2812b_anim_ctrl

Overview:
Frame scheduler and write-port arbiter in front of the ws2812b strip driver's colour-memory write port (color / nb_led / write). Once per frame period it sweeps a generated animation pattern (chase, fill or blink) into all LED slots. It also shares that write port with a host requester using a fixed-priority, starvation-free arbitration rule.

Parameters:
FCLK, 100, clock frequency in MHz
NB_LEDS, 5, number of LEDs on the strip; must match the driver
FRAME_US, 20000, frame period in microseconds; CFRAME = FRAME_US*FCLK clock cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  allows a sweep to start at a frame tick
mode  in  2  0 = host-only, 1 = chase, 2 = fill, 3 = blink
fg_color  in  24  foreground GRB colour
bg_color  in  24  background GRB colour
host_req  in  1  host write request; held until host_ack
host_led  in  32  host target LED index
host_color  in  24  host colour
host_ack  out  1  one-cycle pulse; host write is in progress this cycle
color  out  24  to driver colour input
nb_led  out  32  to driver LED-index input
write  out  1  to driver write strobe
frame_tick  out  1  one-cycle pulse per frame period
busy  out  1  high while a sweep is in progress

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- All outputs are registered.
- Reset values: color=0, nb_led=0, write=0, host_ack=0, frame_tick=0, busy=0. Internal reset values: timer=0, state=IDLE, idx=0, pos=0, phase=0, last_mode=0.
- Reset mid-sweep aborts the sweep immediately; no further writes are issued.
- Frame timer:
  - Counts 0..CFRAME-1 and wraps.
  - frame_tick is high for the single cycle after the timer's terminal count.
  - The timer runs regardless of enable and mode.
- FSM states: IDLE and SWEEP.
  - IDLE -> SWEEP: at the edge that raises frame_tick, if enable=1, mode!=0 and state=IDLE.
  - On that transition: latch mode, fg_color and bg_color; set idx=0.
  - If the latched mode differs from last_mode, clear pos and phase, then update last_mode.
  - A frame tick that arrives while in SWEEP is dropped; it is not queued.
  - Deasserting enable mid-sweep does not stop the sweep; it runs to completion.
- SWEEP write cycle (port not granted to host): write=1, nb_led=idx, color=pattern(idx), idx++.
  - After idx=NB_LEDS-1 is written, return to IDLE.
  - On exit: pos = (pos==NB_LEDS-1) ? 0 : pos+1; phase toggles.
- Patterns, evaluated for each index i:
  - chase: fg if i==pos, else bg.
  - fill: fg if i<=pos, else bg.
  - blink: fg if phase==0, else bg.
- Latency with no contention:
  - frame_tick high in cycle T.
  - Writes in cycles T+1 .. T+NB_LEDS.
  - busy high in the same cycles T+1 .. T+NB_LEDS.
- Host arbitration (1-cycle latency):
  - If host_req is sampled high at an edge and host_ack is low in the current cycle, the next cycle has write=1, nb_led=host_led, color=host_color, host_ack=1.
  - Host wins over a pending sweep write; the sweep stalls that cycle, holding idx.
  - host_req is ignored in any cycle where host_ack=1. This prevents a double write and guarantees the sweep at least every other cycle.
  - Host writes are allowed in any mode, including mode 0, and in either state.
- Write strobe: write is low in every cycle with no sweep write and no host write. color and nb_led hold their last values.
- Host index range: a host_led >= NB_LEDS is still forwarded unmodified. Range checking is the driver's concern.

Optional Feature:
ANIM_BRIGHTNESS_EN
- With the macro defined:
  - Adds input port brightness[7:0].
  - Each 8-bit channel c of a sweep write becomes (c*(brightness+1))>>8. brightness=255 is identity; brightness=0 gives 0x00 for every input value.
  - brightness is latched at sweep start together with the colours.
  - Host writes are never scaled.
  - Latency is unchanged.
- Without the macro: no brightness port; sweep colours are passed through unmodified.

Test Plan:
All scenarios use FCLK=100, FRAME_US=1 (CFRAME=100), NB_LEDS=5.

1. Reset then idle: rst high 3 cycles, enable=0 -> all outputs 0; frame_tick pulses every 100 cycles; write never asserted.
2. Chase: enable=1, mode=1, fg=FF0000, bg=000000 -> three frames write indices 0..4 on consecutive cycles. fg appears at index 0, then 1, then 2; all other indices get bg; busy is high for exactly 5 cycles per frame.
3. Fill wrap: mode=2, run 6 frames -> frame 5 writes fg to all 5 LEDs; frame 6 writes fg only at index 0.
4. Host contention: mode=3, host_req held high from the frame_tick cycle, host_led=2, color=00FF00 -> single host write with host_ack in cycle T+1. Sweep index 0 is written in T+2; all 5 sweep writes finish by T+6; no second host write.
5. Reset mid-sweep: assert rst in the third write cycle -> write=0 and busy=0 in the next cycle; the next frame restarts at index 0 with pos=0.
6. ANIM_BRIGHTNESS_EN: brightness=127, fg=FF8040 -> sweep writes 7F4020; a concurrent host write of FF8040 passes through unscaled.

Source files
------------

// File: rtl/ws2812b_anim_ctrl.sv
// Frame scheduler and write-port arbiter for the ws2812b colour-memory port.
// Optional macro ANIM_BRIGHTNESS_EN adds a brightness input that scales sweep colours.
module ws2812b_anim_ctrl #(
    parameter int FCLK     = 100,
    parameter int NB_LEDS  = 5,
    parameter int FRAME_US = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
`ifdef ANIM_BRIGHTNESS_EN
    input  logic [7:0]  brightness,
`endif
    input  logic        host_req,
    input  logic [31:0] host_led,
    input  logic [23:0] host_color,
    output logic        host_ack,
    output logic [23:0] color,
    output logic [31:0] nb_led,
    output logic        write,
    output logic        frame_tick,
    output logic        busy
);

    localparam int CFRAME = FRAME_US * FCLK;
    localparam int TW     = (CFRAME > 1) ? $clog2(CFRAME) : 1;
    localparam int IW     = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
    localparam logic [TW-1:0] TLAST = TW'(CFRAME - 1);
    localparam logic [IW-1:0] LAST  = IW'(NB_LEDS - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic [IW-1:0] idx, pos;
    logic          phase;
    logic [1:0]    mode_l, last_mode;
    logic [23:0]   fg_l, bg_l, sweep_color;
    logic          tick_nx, host_go, sweep_go, start;
`ifdef ANIM_BRIGHTNESS_EN
    logic [7:0]    bright_l;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = 17'(c) * 17'({1'b0, b} + 9'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] c, input logic [7:0] b);
        return {scale8(c[23:16], b), scale8(c[15:8], b), scale8(c[7:0], b)};
    endfunction
`endif

    function automatic logic [23:0] pattern(input logic [1:0] m, input logic [IW-1:0] i,
                                            input logic [IW-1:0] p, input logic ph,
                                            input logic [23:0] fg, input logic [23:0] bg);
        case (m)
            2'd1:    return (i == p) ? fg : bg;
            2'd2:    return (i <= p) ? fg : bg;
            2'd3:    return ph ? bg : fg;
            default: return bg;
        endcase
    endfunction

    // Host wins the port unless it was served last cycle, so the sweep gets every other slot.
    always_comb begin
        state_nx = state;
        tick_nx  = (timer == TLAST);
        host_go  = host_req && !host_ack;
        sweep_go = (state == SWEEP) && !host_go;
        start    = (state == IDLE) && tick_nx && enable && (mode != 2'd0);
`ifdef ANIM_BRIGHTNESS_EN
        sweep_color = scale_grb(pattern(mode_l, idx, pos, phase, fg_l, bg_l), bright_l);
`else
        sweep_color = pattern(mode_l, idx, pos, phase, fg_l, bg_l);
`endif
        case (state)
            IDLE:    if (start) state_nx = SWEEP;
            SWEEP:   if (sweep_go && idx == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            frame_tick <= 1'b0;
            write      <= 1'b0;
            host_ack   <= 1'b0;
            busy       <= 1'b0;
            color      <= '0;
            nb_led     <= '0;
            idx        <= '0;
            pos        <= '0;
            phase      <= 1'b0;
            mode_l     <= '0;
            last_mode  <= '0;
        end else begin
            timer      <= tick_nx ? '0 : timer + 1'b1;
            frame_tick <= tick_nx;
            busy       <= (state == SWEEP);
            write      <= host_go || sweep_go;
            host_ack   <= host_go;
            if (host_go) begin
                nb_led <= host_led;
                color  <= host_color;
            end else if (sweep_go) begin
                nb_led <= 32'(idx);
                color  <= sweep_color;
                idx    <= idx + 1'b1;
                if (idx == LAST) begin
                    pos   <= (pos == LAST) ? '0 : pos + 1'b1;
                    phase <= ~phase;
                end
            end
            if (start) begin
                mode_l <= mode;
                idx    <= '0;
                if (mode != last_mode) begin
                    pos       <= '0;
                    phase     <= 1'b0;
                    last_mode <= mode;
                end
            end
        end
    end

    // Sweep colours are captured once per sweep; they carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            fg_l <= fg_color;
            bg_l <= bg_color;
`ifdef ANIM_BRIGHTNESS_EN
            bright_l <= brightness;
`endif
        end
    end

endmodule

// File: tb/tb_ws2812b_anim_ctrl.sv
// Directed bench for ws2812b_anim_ctrl with a 100-cycle frame and 5 LEDs.
module tb_ws2812b_anim_ctrl;

    localparam int NB = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] fg_color = '0, bg_color = '0, host_color = '0;
    logic        host_req = 1'b0;
    logic [31:0] host_led = '0;
    logic        host_ack, write, frame_tick, busy;
    logic [23:0] color;
    logic [31:0] nb_led;
`ifdef ANIM_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'd255;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ws2812b_anim_ctrl #(.FCLK(100), .NB_LEDS(NB), .FRAME_US(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .fg_color(fg_color), .bg_color(bg_color),
`ifdef ANIM_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .host_req(host_req), .host_led(host_led), .host_color(host_color),
        .host_ack(host_ack), .color(color), .nb_led(nb_led), .write(write),
        .frame_tick(frame_tick), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        int wr;
        wr = 0;
        n  = 0;
        do begin
            step();
            n++;
            if (write === 1'b1) wr++;
        end while (frame_tick !== 1'b1 && n < 300);
        check("tick_seen", 32'(frame_tick), 1);
        check("idle_write", wr, 0);
    endtask

    // One frame: optional host write in T+1, then five sweep writes; fgmask bit i selects fg at LED i.
    task automatic sweep(input string tag, input logic [4:0] fgmask, input logic [23:0] fgx,
                         input logic [23:0] bgx, input bit with_host, input logic [23:0] hcol);
        int n;
        wait_tick(n);
        if (with_host) begin
            host_req   = 1'b1;
            host_led   = 32'd2;
            host_color = hcol;
            step();
            check({tag, "_hwr"}, 32'(write), 1);
            check({tag, "_hack"}, 32'(host_ack), 1);
            check({tag, "_hled"}, nb_led, 2);
            check({tag, "_hcol"}, 32'(color), 32'(hcol));
            check({tag, "_hbusy"}, 32'(busy), 1);
        end
        for (int i = 0; i < NB; i++) begin
            step();
            check({tag, "_wr"}, 32'(write), 1);
            check({tag, "_led"}, nb_led, 32'(i));
            check({tag, "_col"}, 32'(color), 32'(fgmask[i] ? fgx : bgx));
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_ack"}, 32'(host_ack), 0);
            check({tag, "_tick"}, 32'(frame_tick), 0);
            if (i == 0) host_req = 1'b0;
        end
        step();
        check({tag, "_endwr"}, 32'(write), 0);
        check({tag, "_endbusy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset and idle timing
        repeat (3) step();
        check("rst_write", 32'(write), 0);
        check("rst_ack", 32'(host_ack), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_color", 32'(color), 0);
        check("rst_led", nb_led, 0);
        rst = 1'b0;
        wait_tick(n);
        wait_tick(n);
        check("tick_period", n, 100);

        // Chase: fg walks 0,1,2
        enable = 1'b1; mode = 2'd1; fg_color = 24'hFF0000; bg_color = 24'h000000;
        sweep("chase0", 5'b00001, 24'hFF0000, 24'h000000, 0, 24'h0);
        sweep("chase1", 5'b00010, 24'hFF0000, 24'h000000, 0, 24'h0);
        sweep("chase2", 5'b00100, 24'hFF0000, 24'h000000, 0, 24'h0);

        // Fill with wrap on the sixth frame
        mode = 2'd2; fg_color = 24'h0000FF; bg_color = 24'h123456;
        sweep("fill0", 5'b00001, 24'h0000FF, 24'h123456, 0, 24'h0);
        sweep("fill1", 5'b00011, 24'h0000FF, 24'h123456, 0, 24'h0);
        sweep("fill2", 5'b00111, 24'h0000FF, 24'h123456, 0, 24'h0);
        sweep("fill3", 5'b01111, 24'h0000FF, 24'h123456, 0, 24'h0);
        sweep("fill4", 5'b11111, 24'h0000FF, 24'h123456, 0, 24'h0);
        sweep("fill5", 5'b00001, 24'h0000FF, 24'h123456, 0, 24'h0);

        // Blink with host contention, then the opposite phase
        mode = 2'd3; fg_color = 24'h0000AA; bg_color = 24'h000055;
        sweep("blink_host", 5'b11111, 24'h0000AA, 24'h000055, 1, 24'h00FF00);
        sweep("blink_ph1", 5'b00000, 24'h0000AA, 24'h000055, 0, 24'h0);

        // Reset during the third sweep write
        mode = 2'd1; fg_color = 24'hFF0000; bg_color = 24'h000000;
        wait_tick(n);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pre_rst_led", nb_led, 32'(i));
            check("pre_rst_wr", 32'(write), 1);
        end
        rst = 1'b1;
        step();
        check("midrst_write", 32'(write), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_led", nb_led, 0);
        check("midrst_color", 32'(color), 0);
        rst = 1'b0;
        sweep("rst_restart", 5'b00001, 24'hFF0000, 24'h000000, 0, 24'h0);

`ifdef ANIM_BRIGHTNESS_EN
        // Scaled sweep, unscaled host write
        brightness = 8'd127; mode = 2'd3; fg_color = 24'hFF8040; bg_color = 24'h000000;
        sweep("bright", 5'b11111, 24'h7F4020, 24'h000000, 1, 24'hFF8040);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
